// File: rtl/axi_ram_pkg.sv
// Shared types for the AXI4 slave RAM: burst/response encodings, FSM states,
// and the WRAP length legality rule.
package axi_ram_pkg;

  typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_e;
  typedef enum logic [1:0] {OKAY = 2'b00, SLVERR = 2'b10} resp_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} wr_state_e;
  typedef enum logic {R_IDLE = 1'b0, R_DATA = 1'b1} rd_state_e;

  function automatic logic legal_wrap_len(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts, plus a flag that
// is low when the burst attributes must be answered with SLVERR.
module axi_burst_addr_gen
  import axi_ram_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int STRB_W = 4
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [2:0]        size_i,
  input  logic [7:0]        len_i,
  input  logic [1:0]        burst_i,
  output logic [ADDR_W-1:0] next_addr_o,
  output logic              legal_o
);

  localparam int         LG       = $clog2(STRB_W);
  localparam logic [2:0] MAX_SIZE = 3'(LG);

  logic [2:0]        eff_size;
  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] inc_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic              wrap_ok;

  always_comb begin
    // Oversized beats are clamped to the bus width; illegal WRAP lengths and
    // the reserved burst code both fall back to INCR.
    eff_size    = (size_i > MAX_SIZE) ? MAX_SIZE : size_i;
    step        = ADDR_W'(1) << eff_size;
    inc_addr    = addr_i + step;
    wrap_mask   = ((ADDR_W'(len_i) + ADDR_W'(1)) << eff_size) - ADDR_W'(1);
    wrap_ok     = legal_wrap_len(len_i);
    legal_o     = (size_i <= MAX_SIZE) && (burst_i != 2'b11) &&
                  !((burst_i == WRAP) && !wrap_ok);
    next_addr_o = inc_addr;
    if (burst_i == FIXED) begin
      next_addr_o = addr_i;
    end else if ((burst_i == WRAP) && wrap_ok) begin
      next_addr_o = (addr_i & ~wrap_mask) | (inc_addr & wrap_mask);
    end
  end

endmodule

// File: rtl/axi_slave_ram.sv
// AXI4 slave backed by a register array; one outstanding burst per direction,
// write and read paths fully independent.
module axi_slave_ram
  import axi_ram_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int ID_W        = 4,
  parameter int DEPTH_WORDS = 1024
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [ID_W-1:0]     awid,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic [7:0]          awlen,
  input  logic [2:0]          awsize,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [DATA_W-1:0]   wdata,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_W-1:0]     bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready,
  input  logic [ID_W-1:0]     arid,
  input  logic [ADDR_W-1:0]   araddr,
  input  logic [7:0]          arlen,
  input  logic [2:0]          arsize,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_W-1:0]     rid,
  output logic [DATA_W-1:0]   rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  output logic [1:0]          dbg_wr_state_o,
  output logic                dbg_rd_state_o
);

  localparam int                STRB_W    = DATA_W / 8;
  localparam int                LG        = $clog2(STRB_W);
  localparam int                AW        = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_W-1:0] MEM_LIMIT = ADDR_W'(DEPTH_WORDS * STRB_W);

  // Handshake rule on every channel: a beat transfers on the rising edge where
  // valid && ready; a raised valid and its payload stay put until that edge.

  logic [DATA_W-1:0] mem [DEPTH_WORDS];
  logic              init_q;

  // ---------------- write path ----------------
  wr_state_e         wr_state_q, wr_state_d;
  logic [ID_W-1:0]   wid_q, wid_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [7:0]        wlen_q, wlen_d, wbeat_q, wbeat_d;
  logic [2:0]        wsize_q, wsize_d;
  logic [1:0]        wburst_q, wburst_d;
  logic              werr_q, werr_d;
  logic [ADDR_W-1:0] w_next;
  logic              w_legal, w_oor, mem_we;
  logic [AW-1:0]     w_word;

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_wr_gen (
    .addr_i(waddr_q), .size_i(wsize_q), .len_i(wlen_q), .burst_i(wburst_q),
    .next_addr_o(w_next), .legal_o(w_legal)
  );

  assign w_oor  = (waddr_q >= MEM_LIMIT);
  assign w_word = waddr_q[LG +: AW];
  assign bid    = wid_q;

  always_comb begin
    wr_state_d = wr_state_q;
    wid_d      = wid_q;
    waddr_d    = waddr_q;
    wlen_d     = wlen_q;
    wsize_d    = wsize_q;
    wburst_d   = wburst_q;
    wbeat_d    = wbeat_q;
    werr_d     = werr_q;
    awready    = 1'b0;
    wready     = 1'b0;
    bvalid     = 1'b0;
    bresp      = OKAY;
    mem_we     = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        awready = init_q;
        if (awvalid && init_q) begin
          wid_d      = awid;
          waddr_d    = awaddr;
          wlen_d     = awlen;
          wsize_d    = awsize;
          wburst_d   = awburst;
          wbeat_d    = 8'd0;
          werr_d     = 1'b0;
          wr_state_d = W_DATA;
        end
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid) begin
          // The beat count, not wlast, closes the burst; a misplaced wlast only flags an error.
          mem_we  = !w_oor;
          werr_d  = werr_q | (wlast != (wbeat_q == wlen_q)) | w_oor;
          waddr_d = w_next;
          wbeat_d = wbeat_q + 8'd1;
          if (wbeat_q == wlen_q) wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = (werr_q || !w_legal) ? SLVERR : OKAY;
        if (bready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      init_q     <= 1'b0;
      wr_state_q <= W_IDLE;
      wid_q      <= '0;
      waddr_q    <= '0;
      wlen_q     <= '0;
      wsize_q    <= '0;
      wburst_q   <= '0;
      wbeat_q    <= '0;
      werr_q     <= 1'b0;
    end else begin
      init_q     <= 1'b1;
      wr_state_q <= wr_state_d;
      wid_q      <= wid_d;
      waddr_q    <= waddr_d;
      wlen_q     <= wlen_d;
      wsize_q    <= wsize_d;
      wburst_q   <= wburst_d;
      wbeat_q    <= wbeat_d;
      werr_q     <= werr_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (aresetn && mem_we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[w_word][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  rd_state_e         rd_state_q, rd_state_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [7:0]        rlen_q, rlen_d, rbeat_q, rbeat_d;
  logic [2:0]        rsize_q, rsize_d;
  logic [1:0]        rburst_q, rburst_d;
  logic              rerr_q, rerr_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;
  logic              rg_idle, r_legal, ld, ld_err, ld_oor;
  logic [ADDR_W-1:0] r_next, ld_addr;
  logic [AW-1:0]     ld_word;

  // While idle the generator judges the incoming AR fields; afterwards it walks the latched burst.
  assign rg_idle = (rd_state_q == R_IDLE);

  axi_burst_addr_gen #(.ADDR_W(ADDR_W), .STRB_W(STRB_W)) u_rd_gen (
    .addr_i (rg_idle ? araddr  : raddr_q),
    .size_i (rg_idle ? arsize  : rsize_q),
    .len_i  (rg_idle ? arlen   : rlen_q),
    .burst_i(rg_idle ? arburst : rburst_q),
    .next_addr_o(r_next), .legal_o(r_legal)
  );

  assign rvalid = (rd_state_q == R_DATA);
  assign rid    = rid_q;
  assign rdata  = rdata_q;
  assign rresp  = rresp_q;
  assign rlast  = rlast_q;

  always_comb begin
    rd_state_d = rd_state_q;
    rid_d      = rid_q;
    raddr_d    = raddr_q;
    rlen_d     = rlen_q;
    rsize_d    = rsize_q;
    rburst_d   = rburst_q;
    rbeat_d    = rbeat_q;
    rerr_d     = rerr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    rlast_d    = rlast_q;
    arready    = 1'b0;
    ld         = 1'b0;
    ld_addr    = raddr_q;
    ld_err     = rerr_q;
    case (rd_state_q)
      R_IDLE: begin
        arready = init_q;
        if (arvalid && init_q) begin
          rid_d      = arid;
          raddr_d    = araddr;
          rlen_d     = arlen;
          rsize_d    = arsize;
          rburst_d   = arburst;
          rbeat_d    = 8'd0;
          rerr_d     = !r_legal;
          rlast_d    = (arlen == 8'd0);
          ld         = 1'b1;
          ld_addr    = araddr;
          ld_err     = !r_legal;
          rd_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          if (rlast_q) begin
            rd_state_d = R_IDLE;
          end else begin
            raddr_d = r_next;
            rbeat_d = rbeat_q + 8'd1;
            rlast_d = ((rbeat_q + 8'd1) == rlen_q);
            ld      = 1'b1;
            ld_addr = r_next;
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
    ld_oor  = (ld_addr >= MEM_LIMIT);
    ld_word = ld_addr[LG +: AW];
    if (ld) begin
      rdata_d = ld_oor ? '0 : mem[ld_word];
      rresp_d = (ld_err || ld_oor) ? SLVERR : OKAY;
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      rd_state_q <= R_IDLE;
      rid_q      <= '0;
      raddr_q    <= '0;
      rlen_q     <= '0;
      rsize_q    <= '0;
      rburst_q   <= '0;
      rbeat_q    <= '0;
      rerr_q     <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= '0;
      rlast_q    <= 1'b0;
    end else begin
      rd_state_q <= rd_state_d;
      rid_q      <= rid_d;
      raddr_q    <= raddr_d;
      rlen_q     <= rlen_d;
      rsize_q    <= rsize_d;
      rburst_q   <= rburst_d;
      rbeat_q    <= rbeat_d;
      rerr_q     <= rerr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
      rlast_q    <= rlast_d;
    end
  end

  assign dbg_wr_state_o = wr_state_q;
  assign dbg_rd_state_o = rd_state_q;

endmodule

// File: tb/tb_axi_slave_ram.sv
// Scoreboarded bench for axi_slave_ram: directed cases plus randomized bursts
// checked against a byte-level reference memory.
module tb_axi_slave_ram;

  localparam int          MEM_BYTES = 4096;
  localparam int          BUDGET    = 200;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic [3:0]  awid, arid, bid, rid;
  logic [31:0] awaddr, araddr, wdata, rdata;
  logic [7:0]  awlen, arlen;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [1:0]  dbg_wr;
  logic        dbg_rd;

  axi_slave_ram dut (
    .aclk(aclk), .aresetn(aresetn),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .dbg_wr_state_o(dbg_wr), .dbg_rd_state_o(dbg_rd)
  );

  // ---------------- clock / reset ----------------
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [5:0]  b_exp_q[$];   // {id, resp}
  logic [38:0] r_exp_q[$];   // {id, data, resp, last}
  logic [31:0] ref_mem [1024];
  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  int          total = 0;
  int          bad   = 0;
  bit          b_low   = 1'b0;
  bit          rnd_rdy = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=0x%0h exp=0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s timeout", name);
  endtask

  // ---------------- reference model ----------------
  function automatic bit wrap_ok(input int len);
    return (len == 1) || (len == 3) || (len == 7) || (len == 15);
  endfunction

  function automatic bit txn_legal(input int len, input int size, input int burst);
    return (size <= 2) && (burst != 3) && !((burst == 2) && !wrap_ok(len));
  endfunction

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int len,
                                            input int size, input int burst, input int i);
    int unsigned bytes, wsize, lower;
    bytes = 1 << ((size > 2) ? 2 : size);
    if (burst == 0) return start;
    if ((burst == 2) && wrap_ok(len)) begin
      wsize = (len + 1) * bytes;
      lower = start - (start % wsize);
      return lower + ((start - lower + i * bytes) % wsize);
    end
    return start + i * bytes;
  endfunction

  // ---------------- drivers ----------------
  initial begin
    bready = 1'b1;
    rready = 1'b1;
    forever begin
      @(posedge aclk);
      #1;
      bready = b_low ? 1'b0 : (rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1);
      rready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  function automatic logic rdy_of(input int ch);
    case (ch)
      0:       return awready;
      1:       return wready;
      default: return arready;
    endcase
  endfunction

  // Entered at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic wait_ready(input int ch, input string name);
    int n = 0;
    @(negedge aclk);
    while (!rdy_of(ch) && n < BUDGET) begin
      n++;
      @(negedge aclk);
    end
    if (n >= BUDGET) fail(name);
    @(posedge aclk);
    #1;
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input int len,
                          input int size, input int burst, input bit bad_wlast,
                          input int abort_after);
    bit          err;
    logic [31:0] a;
    err = !txn_legal(len, size, burst) || bad_wlast;
    for (int i = 0; i <= len; i++) begin
      if (abort_after >= 0 && i >= abort_after) break;
      a = beat_addr(addr, len, size, burst, i);
      if (a >= MEM_BYTES) err = 1'b1;
      else for (int b = 0; b < 4; b++) if (ws[i][b]) ref_mem[a >> 2][8*b +: 8] = wd[i][8*b +: 8];
    end
    if (abort_after < 0) b_exp_q.push_back({id, err ? 2'b10 : 2'b00});
    awid = id; awaddr = addr; awlen = 8'(len); awsize = 3'(size); awburst = 2'(burst);
    awvalid = 1'b1;
    wait_ready(0, "aw_ready");
    awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      if (abort_after >= 0 && i == abort_after) begin
        aresetn = 1'b0;
        return;
      end
      repeat ($urandom_range(0, 1)) begin
        @(posedge aclk);
        #1;
      end
      wdata = wd[i]; wstrb = ws[i];
      wlast = (i == len) ^ (bad_wlast && i == 0);
      wvalid = 1'b1;
      wait_ready(1, "w_ready");
      wvalid = 1'b0;
      wlast = 1'b0;
    end
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input int len,
                         input int size, input int burst);
    logic [31:0] a, d;
    bit          oor;
    for (int i = 0; i <= len; i++) begin
      a   = beat_addr(addr, len, size, burst, i);
      oor = (a >= MEM_BYTES);
      d   = oor ? 32'h0 : ref_mem[a >> 2];
      r_exp_q.push_back({id, d, (oor || !txn_legal(len, size, burst)) ? 2'b10 : 2'b00, 1'(i == len)});
    end
    arid = id; araddr = addr; arlen = 8'(len); arsize = 3'(size); arburst = 2'(burst);
    arvalid = 1'b1;
    wait_ready(2, "ar_ready");
    arvalid = 1'b0;
  endtask

  task automatic wait_b();
    int n = 0;
    while (b_exp_q.size() != 0 && n < BUDGET) begin
      n++;
      @(negedge aclk);
    end
    if (n >= BUDGET) begin
      fail("b_wait");
      b_exp_q.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic wait_r();
    int n = 0;
    while (r_exp_q.size() != 0 && n < BUDGET) begin
      n++;
      @(negedge aclk);
    end
    if (n >= BUDGET) begin
      fail("r_wait");
      r_exp_q.delete();
    end
    @(posedge aclk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check(name, {awready, wready, bvalid, bid, bresp, arready, rvalid, rid, rdata, rresp, rlast,
                 dbg_wr, dbg_rd}, 64'h0);
  endtask

  task automatic release_reset();
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    @(negedge aclk);
    check("awready_before_rise", awready, 0);
    @(negedge aclk);
    check("awready_rise", awready, 1);
    check("arready_rise", arready, 1);
    @(posedge aclk);
    #1;
  endtask

  task automatic fill_random(input int len);
    for (int i = 0; i <= len; i++) begin
      wd[i] = $urandom;
      ws[i] = 4'hF;
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [5:0]  e_b, b_prev;
    logic [38:0] e_r, r_prev;
    bit          b_stall = 1'b0, r_stall = 1'b0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        b_stall = 1'b0;
        r_stall = 1'b0;
      end else begin
        if (b_stall) check("b_hold", {bvalid, bid, bresp}, {1'b1, b_prev});
        if (r_stall) check("r_hold", {rvalid, rid, rdata, rresp, rlast}, {1'b1, r_prev});
        if (bvalid && bready) begin
          if (b_exp_q.size() == 0) check("b_unexpected", bvalid, 0);
          else begin
            e_b = b_exp_q.pop_front();
            check("b_resp", {bid, bresp}, e_b);
          end
        end
        if (rvalid && rready) begin
          if (r_exp_q.size() == 0) check("r_unexpected", rvalid, 0);
          else begin
            e_r = r_exp_q.pop_front();
            check("r_beat", {rid, rdata, rresp, rlast}, e_r);
          end
        end
        b_stall = bvalid && !bready;
        b_prev  = {bid, bresp};
        r_stall = rvalid && !rready;
        r_prev  = {rid, rdata, rresp, rlast};
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    logic [31:0] addr;
    int len, size, burst;
    aresetn = 1'b0;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; wlast = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0;
    arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0;
    wdata = '0; wstrb = '0;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check_idle_outputs("reset_outputs");
    release_reset();

    // Zero the low region so the model and the array agree before any reads.
    for (int blk = 0; blk < 8; blk++) begin
      for (int i = 0; i < 16; i++) begin wd[i] = 32'h0; ws[i] = 4'hF; end
      do_write(4'(blk), 32'(blk * 64), 15, 2, 1, 1'b0, -1);
      wait_b();
    end

    // INCR write then read back
    for (int i = 0; i < 4; i++) begin wd[i] = 32'(i + 1); ws[i] = 4'hF; end
    do_write(4'd5, 32'h10, 3, 2, 1, 1'b0, -1);
    wait_b();
    do_read(4'd5, 32'h10, 3, 2, 1);
    wait_r();

    // WRAP ordering 0x38,0x3C,0x30,0x34
    fill_random(3);
    do_write(4'd2, 32'h38, 3, 2, 2, 1'b0, -1);
    wait_b();
    do_read(4'd2, 32'h30, 3, 2, 1);
    wait_r();
    do_read(4'd2, 32'h38, 3, 2, 2);
    wait_r();

    // Byte strobes merge
    wd[0] = 32'hAABBCCDD; ws[0] = 4'hF;
    do_write(4'd1, 32'h0, 0, 2, 1, 1'b0, -1);
    wait_b();
    wd[0] = 32'h11223344; ws[0] = 4'b0101;
    do_write(4'd1, 32'h0, 0, 2, 1, 1'b0, -1);
    wait_b();
    do_read(4'd1, 32'h0, 0, 2, 1);
    wait_r();

    // B back-pressure and R stalls
    fill_random(2);
    b_low = 1'b1;
    do_write(4'd3, 32'h100, 2, 2, 1, 1'b0, -1);
    n = 0;
    while (!bvalid && n < BUDGET) begin n++; @(negedge aclk); end
    if (n >= BUDGET) fail("bvalid_wait");
    repeat (5) begin
      @(negedge aclk);
      check("stall_awready", awready, 0);
      check("stall_bvalid", bvalid, 1);
    end
    @(posedge aclk);
    #1;
    b_low = 1'b0;
    wait_b();
    rnd_rdy = 1'b1;
    do_read(4'd3, 32'h100, 2, 2, 1);
    wait_r();
    rnd_rdy = 1'b0;

    // Error responses: out of range, reserved burst, misplaced wlast
    fill_random(1);
    do_write(4'd4, 32'h1000, 1, 2, 1, 1'b0, -1);
    wait_b();
    do_read(4'd4, 32'h1000, 1, 2, 1);
    wait_r();
    do_read(4'd4, 32'h0, 1, 2, 1);
    wait_r();
    fill_random(1);
    do_write(4'd6, 32'h200, 1, 2, 3, 1'b0, -1);
    wait_b();
    do_read(4'd6, 32'h200, 1, 2, 3);
    wait_r();
    fill_random(1);
    do_write(4'd7, 32'h300, 1, 2, 1, 1'b1, -1);
    wait_b();

    // Reset in the middle of a write burst
    fill_random(3);
    do_write(4'd8, 32'h0, 3, 2, 1, 1'b0, -1);
    wait_b();
    fill_random(3);
    do_write(4'd9, 32'h0, 3, 2, 1, 1'b0, 2);
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    check_idle_outputs("abort_outputs");
    release_reset();
    do_read(4'd9, 32'h0, 3, 2, 1);
    wait_r();

    // Randomized bursts
    for (int t = 0; t < 40; t++) begin
      rnd_rdy = (t % 2) == 1;
      addr  = (t % 8 == 7) ? 32'h1000 + 4 * $urandom_range(0, 63) : 4 * $urandom_range(0, 1023);
      len   = $urandom_range(0, 15);
      size  = $urandom_range(0, 3);
      burst = $urandom_range(0, 3);
      for (int i = 0; i < 16; i++) begin wd[i] = $urandom; ws[i] = 4'($urandom_range(0, 15)); end
      do_write(4'($urandom_range(0, 15)), addr, len, size, burst, 1'b0, -1);
      wait_b();
      do_read(4'($urandom_range(0, 15)), addr, len, size, burst);
      wait_r();
    end
    rnd_rdy = 1'b0;

    repeat (3) @(posedge aclk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
